// File: rtl/xor_crypt_arbiter.sv
// -----------------------------------------------------------------------------
// xor_crypt_arbiter
//
// Purpose
//   Shares one XOR encryption datapath (out = data ^ key) between two
//   requesters. A round-robin arbiter picks one requester per cycle and the
//   encrypted word lands in a single output register stage that drains
//   through a valid/ready handshake. With ROTATE=1 the key rotates left by
//   one bit after every accepted word, producing a simple keystream.
//
// Parameters
//   DATA_W   width of data words, key and ciphertext
//   ROTATE   1: rotate key left by 1 after each accepted word, 0: static key
//   COUNT_W  width of the accepted-word counter
//
// Ports
//   clk         in   rising-edge system clock
//   rst         in   asynchronous active-high reset
//   key_load    in   load key_in into the key register this cycle
//   key_in      in   new key value
//   req0_valid  in   requester 0 has a word
//   req0_data   in   requester 0 plaintext
//   req0_ready  out  requester 0 word accepted this cycle
//   req1_valid  in   requester 1 has a word
//   req1_data   in   requester 1 plaintext
//   req1_ready  out  requester 1 word accepted this cycle
//   out_valid   out  output register holds a ciphertext word
//   out_data    out  ciphertext
//   out_src     out  index of the requester that supplied out_data
//   out_ready   in   sink accepts out_data this cycle
//   word_count  out  accepted-word count, wraps modulo 2^COUNT_W
// -----------------------------------------------------------------------------
module xor_crypt_arbiter #(
    parameter int DATA_W  = 8,
    parameter bit ROTATE  = 1'b1,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_load,
    input  logic [DATA_W-1:0]  key_in,
    input  logic               req0_valid,
    input  logic [DATA_W-1:0]  req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [DATA_W-1:0]  req1_data,
    output logic               req1_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_src,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] word_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               last_grant;
    logic [DATA_W-1:0]  key;

    logic               accept;
    logic               grant;
    logic               transfer;
    logic [DATA_W-1:0]  grant_data;

    // -------------------------------------------------------------------------
    // Arbitration and handshake (combinational, same cycle)
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned -- otherwise synthesis infers a latch.
        accept     = 1'b0;
        grant      = 1'b0;
        transfer   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        // The output register can take a word when it is empty, or when the
        // word it holds leaves this very cycle (no bubble).
        accept = (state == EMPTY) || out_ready;

        // Only one valid: that one wins. Both valid: the one not served last.
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end

        transfer   = accept && (req0_valid || req1_valid);
        req0_ready = transfer && !grant;
        req1_ready = transfer &&  grant;
    end

    assign grant_data = grant ? req1_data : req0_data;
    assign out_valid  = (state == FULL);

    // -------------------------------------------------------------------------
    // Output FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: begin
                if (transfer) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (transfer) begin
                    state_next = FULL;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin pointer: moves only when a word is actually accepted
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Points at requester 1 so requester 0 wins the first contention.
            last_grant <= 1'b1;
        end else if (transfer) begin
            last_grant <= grant;
        end
    end

    // -------------------------------------------------------------------------
    // Output register. Loaded only on transfer, so it holds steady while the
    // sink stalls. It is reset too, so a word in flight at reset is dropped.
    // -------------------------------------------------------------------------
    // NOTE: this is a single register stage, not a memory array, so it is
    // cheap to reset and gives deterministic out_data after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_src  <= 1'b0;
        end else if (transfer) begin
            // Uses the key value from before this edge, so a word accepted in
            // the same cycle as key_load is encrypted with the old key.
            out_data <= grant_data ^ key;
            out_src  <= grant;
        end
    end

    // -------------------------------------------------------------------------
    // Key register: an explicit load beats rotation.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key <= '0;
        end else if (key_load) begin
            key <= key_in;
        end else if (ROTATE && transfer) begin
            key <= {key[DATA_W-2:0], key[DATA_W-1]};
        end
    end

    // -------------------------------------------------------------------------
    // Accepted-word counter, wraps naturally from all-ones to zero.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (transfer) begin
            word_count <= word_count + COUNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Protocol properties
    // -------------------------------------------------------------------------
    a_single_ready : assert property (
        @(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready)
    );

    a_hold_on_stall : assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src))
    );

endmodule

// File: tb/tb_xor_crypt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xor_crypt_arbiter
//
// Directed stimulus with hand-computed ciphertext. The driver pushes each
// expected (data, src) pair into a scoreboard queue; an independent monitor
// pops and compares whenever the sink handshake completes. A second instance
// with COUNT_W=4 sees identical stimulus to exercise counter wrap.
// -----------------------------------------------------------------------------
module tb_xor_crypt_arbiter;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              key_load = 1'b0;
    logic [DATA_W-1:0] key_in = '0;
    logic              req0_valid = 1'b0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req1_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_ready = 1'b0;
    logic [15:0]       word_count;

    // narrow-counter instance outputs
    logic              n_req0_ready;
    logic              n_req1_ready;
    logic              n_out_valid;
    logic [DATA_W-1:0] n_out_data;
    logic              n_out_src;
    logic [3:0]        n_word_count;

    xor_crypt_arbiter #(.DATA_W(DATA_W), .ROTATE(1'b1), .COUNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .key_in     (key_in),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    xor_crypt_arbiter #(.DATA_W(DATA_W), .ROTATE(1'b1), .COUNT_W(4)) dut_narrow (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .key_in     (key_in),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (n_req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (n_req1_ready),
        .out_valid  (n_out_valid),
        .out_data   (n_out_data),
        .out_src    (n_out_src),
        .out_ready  (out_ready),
        .word_count (n_word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              src;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // keystream of 0x5A rotated left once per word
    logic [DATA_W-1:0] ks_5a [8] = '{8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96, 8'h2D};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic s);
        exp_t e;
        e.data = d;
        e.src  = s;
        sb.push_back(e);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: one sink handshake per cycle, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got data 0x%0h src %0d, expected no word", out_data, out_src);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_data", 32'(out_data), 32'(mon_e.data));
                    check("sb_src",  32'(out_src),  32'(mon_e.src));
                end
            end
        end
    end

    initial begin
        // ---------------- 1: reset ----------------
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // park a word in the output register (key 0, sink stalled)
        req0_valid = 1'b1;
        req0_data  = 8'h11;
        out_ready  = 1'b0;
        tick();
        req0_valid = 1'b0;
        #1;
        check("t1_pre_out_valid", 32'(out_valid), 32'd1);
        check("t1_pre_out_data",  32'(out_data),  32'h11);
        #1 rst = 1'b1;
        #1;
        check("t1_rst_out_valid",  32'(out_valid),    32'd0);
        check("t1_rst_out_data",   32'(out_data),     32'h00);
        check("t1_rst_out_src",    32'(out_src),      32'd0);
        check("t1_rst_word_count", 32'(word_count),   32'd0);
        check("t1_rst_key",        32'(dut.key),      32'h00);
        check("t1_rst_n_count",    32'(n_word_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h00;
        #1;
        check("t1_req0_ready", 32'(req0_ready), 32'd1);
        check("t1_req1_ready", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;

        // ---------------- 2: single word ----------------
        tick();
        key_load = 1'b1;
        key_in   = 8'hA5;
        tick();
        key_load   = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h3C;
        out_ready  = 1'b1;
        push(8'h99, 1'b0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_out_data",  32'(out_data),  32'h99);
        check("t2_out_src",   32'(out_src),   32'd0);
        check("t2_key",       32'(dut.key),   32'h4B);
        tick();
        check("t2_word_count", 32'(word_count), 32'd1);
        check("t2_drained",    32'(out_valid),  32'd0);

        // ---------------- 3: contention ----------------
        do_reset();
        key_load = 1'b1;
        key_in   = 8'h01;
        tick();
        key_load   = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h10;
        req1_valid = 1'b1;
        req1_data  = 8'h20;
        out_ready  = 1'b1;
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        push(8'h14, 1'b0);
        push(8'h28, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_req0_ready", 32'(req0_ready), 32'(i % 2 == 0));
            check("t3_req1_ready", 32'(req1_ready), 32'(i % 2 == 1));
            check("t3_word_count", 32'(word_count), 32'(i));
            if (i > 0) begin
                check("t3_out_valid", 32'(out_valid), 32'd1);
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // ---------------- 4: backpressure ----------------
        out_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h33;
        req1_valid = 1'b1;
        req1_data  = 8'h44;
        push(8'h23, 1'b0);
        #1;
        check("t4_first_req0_ready", 32'(req0_ready), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_req0_ready",  32'(req0_ready), 32'd0);
            check("t4_req1_ready",  32'(req1_ready), 32'd0);
            check("t4_out_data",    32'(out_data),   32'h23);
            check("t4_out_src",     32'(out_src),    32'd0);
            check("t4_word_count",  32'(word_count), 32'd5);
            check("t4_key",         32'(dut.key),    32'h20);
            tick();
        end
        out_ready = 1'b1;
        push(8'h64, 1'b1);
        #1;
        check("t4_resume_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // ---------------- 5: key_load with transfer ----------------
        key_load = 1'b1;
        key_in   = 8'h0F;
        tick();
        key_in     = 8'hF0;
        req1_valid = 1'b1;
        req1_data  = 8'hFF;
        push(8'hF0, 1'b1);
        #1;
        check("t5_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        key_load   = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("t5_key",        32'(dut.key),    32'hF0);
        check("t5_word_count", 32'(word_count), 32'd7);
        tick();

        // ---------------- 6: counter wrap and key period ----------------
        do_reset();
        key_load = 1'b1;
        key_in   = 8'h5A;
        tick();
        key_load   = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h00;
        for (int i = 0; i < 17; i++) begin
            push(ks_5a[i % 8], 1'b0);
        end
        for (int i = 0; i < 17; i++) begin
            #1;
            check("t6_req0_ready", 32'(req0_ready), 32'd1);
            if (i == 8) begin
                check("t6_key_period", 32'(dut.key),     32'h5A);
                check("t6_n_count_8",  32'(n_word_count), 32'd8);
            end
            tick();
        end
        req0_valid = 1'b0;
        #1;
        check("t6_n_word_count", 32'(n_word_count), 32'd1);
        check("t6_word_count",   32'(word_count),   32'd17);
        check("t6_key_end",      32'(dut.key),      32'hB4);
        tick();
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
